bf_io_arbiter: RTL

Shares one host byte-stream port between `N_MACHINES` `bf_machine` instances. Host input words carry a machine ID and are routed to that machine's input channel. Pending machine outputs are collected round-robin and returned to the host tagged with the source ID. The block sits between the host I/O front end (UART/testbench) and the array of interpreters.

---
 rtl/bf_pkg.sv | 16 +
 rtl/bf_rr_picker.sv | 31 +++
 rtl/bf_io_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the bf_machine array and its host I/O arbiter.
//   BF_WORD_SIZE : default data word width of a bf_machine
//   t_word       : one machine data word
//   t_out_state  : states of the arbiter's output-collection FSM
package bf_pkg;

  localparam int BF_WORD_SIZE = 8;

  typedef logic [BF_WORD_SIZE-1:0] t_word;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } t_out_state;

endpackage

// File: rtl/bf_rr_picker.sv
// Combinational round-robin find-first-set.
// Searches req starting at index ptr, upward with wrap-around.
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts
//   found : at least one request is set
//   idx   : first requesting index at or after ptr (mod N)
module bf_rr_picker
  import bf_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bf_io_arbiter.sv
// Shares one host word port between N_MACHINES bf_machine instances.
// Host words carry a destination ID and are routed through a single
// holding register; machine outputs are collected round-robin and
// returned to the host tagged with the source ID.
//   clk, rst                  : clock, synchronous active-high reset
//   host_in_*                 : host -> arbiter word, ID, handshake
//   host_out_*                : arbiter -> host word, ID, handshake
//   machine_input*            : arbiter -> machines (flat N x WORD_SIZE)
//   machine_output*           : machines -> arbiter (flat N x WORD_SIZE)
//   err_bad_id                : sticky flag, host sent ID >= N_MACHINES
module bf_io_arbiter
  import bf_pkg::*;
#(
  parameter int N_MACHINES = 4,
  parameter int WORD_SIZE  = BF_WORD_SIZE,
  localparam int ID_W = $clog2(N_MACHINES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_SIZE-1:0]            host_in_word,
  input  logic [ID_W-1:0]                 host_in_id,
  input  logic                            host_in_valid,
  output logic                            host_in_ready,
  output logic [WORD_SIZE-1:0]            host_out_word,
  output logic [ID_W-1:0]                 host_out_id,
  output logic                            host_out_valid,
  input  logic                            host_out_ready,
  output logic [N_MACHINES*WORD_SIZE-1:0] machine_input,
  output logic [N_MACHINES-1:0]           machine_input_valid,
  input  logic [N_MACHINES-1:0]           machine_input_ready,
  input  logic [N_MACHINES*WORD_SIZE-1:0] machine_output,
  input  logic [N_MACHINES-1:0]           machine_output_valid,
  output logic [N_MACHINES-1:0]           machine_output_ready,
  output logic                            err_bad_id
);

  logic [WORD_SIZE-1:0] hold_word;
  logic [ID_W-1:0]      hold_id;
  logic                 hold_valid;
  logic                 in_accept;
  logic                 in_id_ok;

  t_out_state           state_q;
  t_out_state           state_d;
  logic [ID_W-1:0]      rr_ptr;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic [WORD_SIZE-1:0] pick_word;
  logic [ID_W-1:0]      rr_next;

  // ---------------- input path: host -> holding register -> machine
  assign host_in_ready = !hold_valid;
  assign in_accept     = host_in_valid && !hold_valid;
  assign in_id_ok      = int'(host_in_id) < N_MACHINES;

  // A new host word can only land when the register is empty, so the
  // drain and the capture never collide in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      err_bad_id <= 1'b0;
    end else begin
      if (hold_valid && machine_input_ready[hold_id]) begin
        hold_valid <= 1'b0;
      end
      if (in_accept) begin
        if (in_id_ok) begin
          hold_valid <= 1'b1;
        end else begin
          err_bad_id <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_accept && in_id_ok) begin
      hold_word <= host_in_word;
      hold_id   <= host_in_id;
    end
  end

  assign machine_input = {N_MACHINES{hold_word}};

  always_comb begin
    machine_input_valid = '0;
    for (int i = 0; i < N_MACHINES; i++) begin
      machine_input_valid[i] = hold_valid && (hold_id == ID_W'(i));
    end
  end

  // ---------------- output path: round-robin collect -> host
  bf_rr_picker #(
    .N (N_MACHINES)
  ) u_picker (
    .req   (machine_output_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_word = machine_output[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];

  // host_out_id still names the granted machine while in HOLD.
  assign rr_next = (host_out_id == ID_W'(N_MACHINES - 1)) ? '0
                                                          : host_out_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_found)     state_d = ST_HOLD;
      ST_HOLD: if (host_out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Only IDLE ever strobes a machine, which keeps the strobe one-hot
  // and single-cycle per grant.
  always_comb begin
    machine_output_ready = '0;
    host_out_valid       = 1'b0;
    case (state_q)
      ST_IDLE: if (pick_found) machine_output_ready[pick_idx] = 1'b1;
      ST_HOLD: host_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_out_word <= '0;
      host_out_id   <= '0;
      rr_ptr        <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_found) begin
        host_out_word <= pick_word;
        host_out_id   <= pick_idx;
      end
      if (state_q == ST_HOLD && host_out_ready) begin
        rr_ptr <= rr_next;
      end
    end
  end

endmodule
